// File: rtl/image_pipe_rx_if.sv
// Pixel stream bundle for image_pipe_rx: the upstream side uses a valid/busy
// handshake and the downstream side uses a valid/ready handshake.
interface image_pipe_rx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              in_eol;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic              out_eol;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_sof, in_eol, out_ready,
    input  busy, out_valid, out_data, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eol, out_ready,
    output busy, out_valid, out_data, out_sof, out_eol
  );
endinterface

// File: rtl/image_pipe_rx.sv
// Image pixel receiver: frame-checking front end feeding a small FIFO, with
// registered busy back-pressure, per-frame line counter and sticky error flags.
module image_pipe_rx #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int BUSY_TH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  image_pipe_rx_if.slave      bus,
  output logic [15:0]         line_cnt,
  output logic                ovf_err,
  output logic                proto_err,
  input  logic                err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
  } beat_t;

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } frame_state_e;

  beat_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  frame_state_e   state_q, state_d;
  logic           last_eol_q;
  logic [15:0]    line_cnt_q, line_cnt_d;
  logic           busy_q;
  logic           ovf_q, proto_q;

  logic  full, frame_ok, push, pop, ovf_set, proto_set;
  beat_t head;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    full      = (cnt_q == CW'(DEPTH));
    frame_ok  = (state_q == ACTIVE) || bus.in_sof;
    push      = bus.in_valid && !full && frame_ok;
    pop       = (cnt_q != '0) && bus.out_ready;
    ovf_set   = bus.in_valid && full;
    // Framing is only judged on beats that reach the FIFO; full drops are overflow only.
    proto_set = bus.in_valid && !full &&
                (((state_q == WAIT_SOF) && !bus.in_sof) ||
                 ((state_q == ACTIVE) && bus.in_sof && !last_eol_q));

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    if (push) begin
      state_d = ACTIVE;
      if (bus.in_sof) begin
        line_cnt_d = {15'd0, bus.in_eol};
      end else if (bus.in_eol && (line_cnt_q != 16'hFFFF)) begin
        line_cnt_d = line_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is tracked by
  // cnt_q and the head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: bus.in_data, sof: bus.in_sof, eol: bus.in_eol};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= WAIT_SOF;
      last_eol_q <= 1'b0;
      line_cnt_q <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        last_eol_q <= bus.in_eol;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      busy_q     <= (cnt_d >= CW'(BUSY_TH));
      // A new error in the same cycle as err_clr must survive the clear.
      ovf_q      <= ovf_set   | (ovf_q   & ~err_clr);
      proto_q    <= proto_set | (proto_q & ~err_clr);
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_data  = bus.out_valid ? head.data : '0;
  assign bus.out_sof   = bus.out_valid & head.sof;
  assign bus.out_eol   = bus.out_valid & head.eol;
  assign bus.busy      = busy_q;
  assign line_cnt      = line_cnt_q;
  assign ovf_err       = ovf_q;
  assign proto_err     = proto_q;

endmodule

// File: tb/tb_image_pipe_rx.sv
// Self-checking bench for image_pipe_rx: accepted beats go into a scoreboard
// queue when driven and are compared as the DUT hands them downstream.
module tb_image_pipe_rx;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] line_cnt;
  logic        ovf_err;
  logic        proto_err;

  image_pipe_rx_if #(.DATA_W(DW)) bus ();

  image_pipe_rx #(.DATA_W(DW), .DEPTH(8), .BUSY_TH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .line_cnt  (line_cnt),
    .ovf_err   (ovf_err),
    .proto_err (proto_err),
    .err_clr   (err_clr)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } beat_t;

  beat_t sb[$];
  beat_t mon_exp;
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream monitor: a handshake seen here is consumed at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_exp.data));
        check("out_sof",  32'(bus.out_sof),  32'(mon_exp.sof));
        check("out_eol",  32'(bus.out_eol),  32'(mon_exp.eol));
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input bit acc);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = s;
    bus.in_eol   = e;
    if (acc) sb.push_back(beat_t'{data: d, sof: s, eol: e});
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    err_clr      = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_released", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    err_clr      = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_sof",   32'(bus.out_sof),   32'd0);
    check("rst_out_eol",   32'(bus.out_eol),   32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_line_cnt",  32'(line_cnt),      32'd0);
    check("rst_ovf_err",   32'(ovf_err),       32'd0);
    check("rst_proto_err", 32'(proto_err),     32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sof    = 1'b0;
    bus.in_eol    = 1'b0;
    bus.out_ready = 1'b0;

    // 4x4 frame, downstream always ready, one-cycle latency.
    do_reset();
    bus.out_ready = 1'b1;
    send(8'h10, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("no_comb_path", 32'(bus.out_valid), 32'd0);
    idle();
    @(negedge clk);
    check("latency_1", 32'(bus.out_valid), 32'd1);
    for (int i = 1; i < 16; i++) begin
      send(8'(8'h10 + i), 1'b0, 1'((i % 4) == 3), 1'b1);
    end
    idle();
    wait_drain(50);
    check("frame_line_cnt", 32'(line_cnt),  32'd4);
    check("frame_ovf",      32'(ovf_err),   32'd0);
    check("frame_proto",    32'(proto_err), 32'd0);

    // Busy-respecting source with downstream stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h20 + i), 1'(i == 0), 1'b0, 1'b1);
    end
    @(negedge clk);
    check("busy_before_th", 32'(bus.busy), 32'd0);
    send(8'h26, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("busy_after_6", 32'(bus.busy), 32'd1);
    idle();
    check("busy_held", 32'(bus.busy), 32'd1);
    bus.out_ready = 1'b1;
    wait_not_busy(20);
    send(8'h27, 1'b0, 1'b1, 1'b1);
    idle();
    wait_drain(50);
    check("busy_src_ovf",  32'(ovf_err),  32'd0);
    check("busy_src_line", 32'(line_cnt), 32'd1);

    // Source ignores busy: ninth beat overflows, clear arrives with it and loses.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h30 + i), 1'(i == 0), 1'(i == 7), 1'b1);
    end
    @(negedge clk);
    check("no_ovf_before_full", 32'(ovf_err), 32'd0);
    send(8'h38, 1'b0, 1'b1, 1'b0);
    err_clr = 1'b1;
    idle();
    check("ovf_set_wins", 32'(ovf_err), 32'd1);
    pulse_clr();
    check("ovf_cleared", 32'(ovf_err), 32'd0);
    bus.out_ready = 1'b1;
    wait_drain(50);
    check("ovf_proto", 32'(proto_err), 32'd0);

    // After reset a non-sof beat is dropped and flagged.
    do_reset();
    bus.out_ready = 1'b1;
    send(8'h40, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("nosof_dropped", 32'(bus.out_valid), 32'd0);
    check("nosof_proto",   32'(proto_err),     32'd1);
    pulse_clr();
    check("proto_cleared", 32'(proto_err), 32'd0);
    send(8'h41, 1'b1, 1'b0, 1'b1);
    send(8'h42, 1'b0, 1'b1, 1'b1);
    idle();
    @(negedge clk);
    check("one_line", 32'(line_cnt), 32'd1);

    // Sof in the middle of a line restarts the frame and flags it.
    send(8'h43, 1'b0, 1'b0, 1'b1);
    send(8'h44, 1'b1, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("midline_sof_proto", 32'(proto_err), 32'd1);
    check("midline_sof_line",  32'(line_cnt),  32'd0);
    pulse_clr();
    send(8'h45, 1'b0, 1'b1, 1'b1);
    send(8'h46, 1'b1, 1'b1, 1'b1);
    idle();
    @(negedge clk);
    check("sof_eol_line",  32'(line_cnt),  32'd1);
    check("sof_eol_proto", 32'(proto_err), 32'd0);
    wait_drain(50);

    // Full FIFO with push and pop together: push dropped, seven beats remain.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h50 + i), 1'(i == 0), 1'(i == 7), 1'b1);
    end
    send(8'h58, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    check("collision_ovf", 32'(ovf_err), 32'd1);
    bus.out_ready = 1'b1;
    wait_drain(50);
    @(negedge clk);
    check("seven_left", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a buffered frame throws the beats away.
    bus.out_ready = 1'b0;
    send(8'h60, 1'b1, 1'b0, 1'b1);
    send(8'h61, 1'b0, 1'b0, 1'b1);
    idle();
    do_reset();
    bus.out_ready = 1'b1;
    send(8'h70, 1'b1, 1'b1, 1'b1);
    idle();
    wait_drain(50);
    @(negedge clk);
    check("post_rst_empty", 32'(bus.out_valid), 32'd0);
    check("post_rst_line",  32'(line_cnt),      32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/image_pipe_rx.md
IMAGE_PIPE_RX -- requirements
Module: image_pipe_rx

Interface
REQ-001 Parameter DATA_W, default 8: pixel data width in bits.
REQ-002 Parameter DEPTH, default 8: receive FIFO depth in beats, power of two, minimum 4.
REQ-003 Parameter BUSY_TH, default 6: FIFO occupancy at which busy asserts; 1 <= BUSY_TH <= DEPTH-2.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_data  input  DATA_W  upstream pixel.
REQ-008 in_sof  input  1  beat is first pixel of frame.
REQ-009 in_eol  input  1  beat is last pixel of line.
REQ-010 busy  output  1  back-pressure to upstream transmitter, registered.
REQ-011 out_valid  output  1  FIFO head valid.
REQ-012 out_data / out_sof / out_eol  output  DATA_W / 1 / 1  FIFO head fields.
REQ-013 out_ready  input  1  downstream accepts head.
REQ-014 line_cnt  output  16  lines completed in current frame.
REQ-015 ovf_err  output  1  sticky: beat dropped on full FIFO.
REQ-016 proto_err  output  1  sticky: framing violation.
REQ-017 err_clr  input  1  single-cycle pulse clearing both sticky errors.

Function
REQ-018 Push condition: in_valid=1, FIFO count < DEPTH, and framing FSM accepts the beat; fields {in_data, in_sof, in_eol} written together.
REQ-019 Pop condition: out_valid=1 and out_ready=1; head advances on the same edge.
REQ-020 Full check uses pre-edge count only: push with count==DEPTH is dropped even when a pop occurs in the same cycle; ovf_err sets.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, data order preserved.
REQ-022 Latency: beat pushed at edge N is visible on out_* after edge N (out_valid high in cycle N+1) when the FIFO was empty; no combinational in-to-out path.
REQ-023 busy is registered: busy = 1 after an edge at which post-update count >= BUSY_TH, else 0.
REQ-024 Upstream stops within 1 cycle of seeing busy; headroom DEPTH-BUSY_TH >= 2 absorbs the in-flight beat without overflow.
REQ-025 Framing FSM states: WAIT_SOF, ACTIVE.
REQ-026 WAIT_SOF: beat with in_sof=1 accepted, go ACTIVE, line_cnt cleared to 0; beat with in_sof=0 dropped, proto_err set, stay.
REQ-027 ACTIVE: beat with in_sof=0 accepted; beat with in_sof=1 accepted as new frame start, line_cnt cleared; proto_err set if the previous accepted beat did not have in_eol=1.
REQ-028 line_cnt increments on each accepted beat with in_eol=1; saturates at 16'hFFFF; a beat with in_sof=1 and in_eol=1 sets line_cnt to 1.
REQ-029 FSM and line_cnt update only on accepted (pushed) beats; beats dropped on full do not advance framing.
REQ-030 Error set and err_clr in the same cycle: set wins.
REQ-031 out_* fields hold stable while out_valid=1 and out_ready=0.

Reset
REQ-032 rst_n=0 asynchronously forces: FIFO empty, out_valid=0, out_data=0, out_sof=0, out_eol=0, busy=0, line_cnt=0, ovf_err=0, proto_err=0, FSM=WAIT_SOF.
REQ-033 Reset mid-frame discards all buffered beats; first post-reset beat must carry in_sof=1.
REQ-034 Deassertion is synchronized by the top level; block needs no extra wait cycles.

Verification
REQ-035 Reset, then 4x4 frame (sof on beat 0, eol every 4th), out_ready=1 -> 16 beats out in order, 1-cycle latency, line_cnt=4, no errors.
REQ-036 out_ready=0, stream 8 beats, busy-respecting source -> busy rises after 6th push, no ovf_err, 8 beats drain in order once out_ready=1.
REQ-037 out_ready=0, source ignores busy, 9 beats -> 9th dropped, ovf_err=1; err_clr pulse -> ovf_err=0.
REQ-038 First beat after reset with in_sof=0 -> dropped, proto_err=1, out_valid stays 0; next sof beat accepted.
REQ-039 in_sof mid-line (no prior eol) -> beat accepted, proto_err=1, line_cnt=0.
REQ-040 Full FIFO, push and pop in same cycle -> push dropped, count=7, ovf_err=1; rst_n low mid-frame -> all outputs to reset values next cycle.
